// File: rtl/mmio_uart_tx.sv
// Store-port sink: bytes stored to UART_ADDR are queued and sent 8N1 LSB-first; with UART_TX_PARITY_EN an even parity bit is added.
// Latency: store at edge E0 puts the start bit on tx from edge E1; never backpressures, bytes arriving on a full FIFO are dropped and counted.

module mmio_uart_tx #(
   parameter logic [31:0] UART_ADDR    = 32'h0001_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 16,
   parameter int          DROP_W       = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          data_write,
   input  logic [7:0]                    data,
   input  logic [31:0]                   data_address,
   output logic                          tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [DROP_W-1:0]             drop_count
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t             state, state_n;
   logic [BAUD_W-1:0]  baud, baud_n;
   logic [2:0]         bit_idx, bit_idx_n;
   logic [7:0]         shift, shift_n;
   logic               tx_n;
   logic               baud_last;
`ifdef UART_TX_PARITY_EN
   logic               par, par_n;
`endif

   logic [7:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [7:0]         head;
   logic               push, pop, push_ok;

   assign head    = mem[rd_ptr];
   assign tx_busy = (state != IDLE) || (fifo_count != '0);

   always_comb begin
      push      = data_write && (data_address == UART_ADDR);
      baud_last = (baud == BAUD_LAST);
   end

   // A full FIFO still takes a byte when the head leaves in the same cycle.
   always_comb begin
      push_ok = push && ((fifo_count < DEPTH_CNT) || pop);
   end

   always_comb begin
      state_n   = state;
      baud_n    = baud;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_n     = par;
`endif
      unique case (state)
         IDLE: begin
            if (fifo_count != '0) begin
               pop     = 1'b1;
               shift_n = head;
`ifdef UART_TX_PARITY_EN
               par_n   = ^head;
`endif
               baud_n  = '0;
               state_n = START;
            end
         end
         START: begin
            if (baud_last) begin
               baud_n    = '0;
               bit_idx_n = '0;
               state_n   = DATA;
            end else begin
               baud_n = baud + BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_n  = '0;
               shift_n = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end else begin
               baud_n = baud + BAUD_W'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_last) begin
               baud_n  = '0;
               state_n = STOP;
            end else begin
               baud_n = baud + BAUD_W'(1);
            end
         end
`endif
         STOP: begin
            if (baud_last) begin
               baud_n = '0;
               // Back-to-back frames: reload straight from the FIFO with no idle bit.
               if (fifo_count != '0) begin
                  pop     = 1'b1;
                  shift_n = head;
`ifdef UART_TX_PARITY_EN
                  par_n   = ^head;
`endif
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               baud_n = baud + BAUD_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            baud_n  = '0;
         end
      endcase
   end

   // tx follows the state being entered so the line is a clean flop output.
   always_comb begin
      tx_n = 1'b1;
      unique case (state_n)
         IDLE:    tx_n = 1'b1;
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_n = par_n;
`endif
         STOP:    tx_n = 1'b1;
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         baud       <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         tx         <= 1'b1;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         drop_count <= '0;
`ifdef UART_TX_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
         tx      <= tx_n;
`ifdef UART_TX_PARITY_EN
         par     <= par_n;
`endif
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({push_ok, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (push && !push_ok && (drop_count != DROP_MAX)) begin
            drop_count <= drop_count + DROP_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised scoreboard bench for mmio_uart_tx: a queue-level model predicts accepted bytes,
// drops and frame start cycles; a line monitor decodes tx and compares against the scoreboard.

module tb_mmio_uart_tx;

   localparam logic [31:0] UADDR = 32'h0001_0000;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int DW    = 3;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME    = NB * CPB;
   localparam int DROP_MAX = (1 << DW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          data_write = 1'b0;
   logic [7:0]    data = 8'h00;
   logic [31:0]   data_address = 32'h0;
   logic          tx;
   logic          tx_busy;
   logic [2:0]    fifo_count;
   logic [DW-1:0] drop_count;

   mmio_uart_tx #(
      .UART_ADDR(UADDR), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DROP_W(DW)
   ) dut (
      .clk(clk), .reset(reset), .data_write(data_write), .data(data),
      .data_address(data_address), .tx(tx), .tx_busy(tx_busy),
      .fifo_count(fifo_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: a byte queue plus the cycle at which the transmitter is free again.
   typedef struct {
      logic [7:0] b;
      int         start_cyc;
   } frame_t;

   logic [7:0] mq[$];
   frame_t     exp_q[$];
   int         free_at = 0;
   int         m_drop  = 0;

   always @(posedge clk) begin : model_p
      bit     pop_now, is_push, acc;
      frame_t f;
      cyc++;
      if (reset) begin
         mq.delete();
         exp_q.delete();
         free_at = 0;
         m_drop  = 0;
      end else begin
         pop_now = (mq.size() > 0) && (cyc >= free_at);
         is_push = data_write && (data_address == UADDR);
         acc     = is_push && ((mq.size() < DEPTH) || pop_now);
         if (pop_now) begin
            f.b         = mq.pop_front();
            f.start_cyc = cyc;
            exp_q.push_back(f);
            free_at = cyc + FRAME;
         end
         if (acc) mq.push_back(data);
         else if (is_push && m_drop < DROP_MAX) m_drop++;
      end
   end

   bit          mon_on = 1'b0;
   int          mon_c = 0;
   int          mon_start = 0;
   logic [NB-1:0] mon_bits = '0;

   always @(negedge clk) begin : monitor_p
      frame_t f;
      chk("fifo_count", int'(fifo_count), mq.size());
      chk("drop_count", int'(drop_count), m_drop);
      chk("tx_busy", int'(tx_busy), int'((cyc < free_at) || (mq.size() != 0)));
      if (reset) begin
         mon_on = 1'b0;
      end else begin
         if (!mon_on && tx == 1'b0) begin
            mon_on    = 1'b1;
            mon_c     = 0;
            mon_start = cyc;
         end
         if (mon_on) begin
            if (mon_c % CPB == CPB / 2) mon_bits[mon_c / CPB] = tx;
            if (mon_c == FRAME - 1) begin
               mon_on = 1'b0;
               chk("frame_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  f = exp_q.pop_front();
                  chk("frame_byte", int'(mon_bits[8:1]), int'(f.b));
                  chk("frame_start_cycle", mon_start, f.start_cyc);
                  chk("start_bit", int'(mon_bits[0]), 0);
                  chk("stop_bit", int'(mon_bits[NB-1]), 1);
`ifdef UART_TX_PARITY_EN
                  chk("parity_bit", int'(mon_bits[9]), int'(^f.b));
`endif
               end
            end
            mon_c++;
         end
      end
   end

   task automatic cyc_drive(input bit w, input logic [31:0] a, input logic [7:0] d);
      data_write   = w;
      data_address = a;
      data         = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc_drive(1'b0, UADDR, 8'h00);
   endtask

   task automatic drain();
      int k = 0;
      while ((mq.size() != 0 || cyc < free_at) && k < 2000) begin
         idle(1);
         k++;
      end
      chk("drain_done", int'(mq.size() == 0 && cyc >= free_at), 1);
      idle(2);
   endtask

   initial begin : stim_p
      int n;
      int r;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Quiet line after reset.
      for (int i = 0; i < 50; i++) begin
         chk("idle_tx", int'(tx), 1);
         chk("idle_busy", int'(tx_busy), 0);
         idle(1);
      end

      // Single byte: start bit appears one edge after the store is sampled.
      cyc_drive(1'b1, UADDR, 8'hA5);
      chk("tx_at_push_edge", int'(tx), 1);
      idle(1);
      chk("tx_low_second_edge", int'(tx), 0);
      n = 0;
      while (tx_busy && n < 200) begin
         idle(1);
         n++;
      end
      chk("frame_len", n, FRAME);
      drain();

      // Near-miss addresses are ignored.
      cyc_drive(1'b1, UADDR + 32'd1, 8'h41);
      cyc_drive(1'b1, 32'h0, 8'h41);
      idle(FRAME);
      chk("bad_addr_count", int'(fifo_count), 0);
      chk("bad_addr_busy", int'(tx_busy), 0);

      // Burst of six: one in flight, four queued, one dropped.
      for (int i = 1; i <= 6; i++) cyc_drive(1'b1, UADDR, 8'(i));
      chk("burst_fifo_count", int'(fifo_count), 4);
      chk("burst_drop", int'(drop_count), 1);

      // Push on a full FIFO exactly when STOP reloads the next byte.
      n = 0;
      while (cyc + 1 != free_at && n < 500) begin
         idle(1);
         n++;
      end
      chk("sync_to_stop", int'(cyc + 1 == free_at), 1);
      cyc_drive(1'b1, UADDR, 8'h07);
      chk("full_pop_push_count", int'(fifo_count), 4);
      chk("full_pop_push_drop", int'(drop_count), 1);
      drain();

      // Reset in the middle of a data bit aborts everything.
      cyc_drive(1'b1, UADDR, 8'hFF);
      cyc_drive(1'b1, UADDR, 8'h11);
      idle(CPB + 4);
      chk("pre_reset_count", int'(fifo_count), 1);
      reset = 1'b1;
      idle(1);
      chk("reset_tx", int'(tx), 1);
      chk("reset_count", int'(fifo_count), 0);
      chk("reset_drop", int'(drop_count), 0);
      chk("reset_busy", int'(tx_busy), 0);
      reset = 1'b0;
      cyc_drive(1'b1, UADDR, 8'h3C);
      drain();

      // Random traffic, including overflow to drop-counter saturation.
      for (int i = 0; i < 200; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6) cyc_drive(1'b1, UADDR, 8'($urandom_range(0, 255)));
         else if (r == 6) cyc_drive(1'b1, UADDR ^ (32'd1 << $urandom_range(0, 31)), 8'($urandom_range(0, 255)));
         else if (r == 7) cyc_drive(1'b0, UADDR, 8'($urandom_range(0, 255)));
         else idle($urandom_range(0, 60));
      end
      drain();
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog_p
      #2000000;
      $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
